// File: rtl/slv_i2c_reg_bank.sv
// I2C slave register bank: decodes the slave address, takes a register pointer,
// then streams writes into or reads out of a small byte-wide register file.
module slv_i2c_reg_bank #(
    parameter int                   DATA_SZ  = 8,
    parameter logic [DATA_SZ-2:0]   SLV_ADDR = 7'h2A,
    parameter int                   REG_NUM  = 16,
    parameter logic [DATA_SZ-1:0]   ID_VAL   = 8'hA5,
    localparam int                  IDX_W    = $clog2(REG_NUM)
) (
    input  logic                CLK,
    input  logic                RST_n,
    input  logic                I_BUSY,
    input  logic [DATA_SZ-2:0]  I_ADDR_SLV,
    input  logic                I_RW,
    input  logic [DATA_SZ-1:0]  I_ADDR_REG,
    input  logic [DATA_SZ-1:0]  I_DATA_RD,
    input  logic                I_DATA_VL,
    input  logic [IDX_W-1:0]    I_APP_IDX,
    output logic                O_ACK,
    output logic [DATA_SZ-1:0]  O_DATA_WR,
    output logic                O_WR_STB,
    output logic [IDX_W-1:0]    O_WR_IDX,
    output logic [DATA_SZ-1:0]  O_APP_DATA
);

    typedef enum logic [2:0] {IDLE, CHK, WR_PTR, WR_DATA, RD, NACK} state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic                 ack_q, ack_d;
    logic                 wrStb_q, wrStb_d;
    logic [IDX_W-1:0]     wrIdx_q, wrIdx_d;
    logic [DATA_SZ-1:0]   dataWr_q, dataWr_d;
    logic [DATA_SZ-1:0]   appData_q, appData_d;
    logic                 wrEn;
    logic [DATA_SZ-1:0]   regs_q [REG_NUM];
    logic                 addrMatch;

    // Pointer bits above the register index are intentionally dropped.
    logic unusedAddrBits;
    assign unusedAddrBits = ^I_ADDR_REG[DATA_SZ-1:IDX_W];

    assign addrMatch = (I_ADDR_SLV == SLV_ADDR);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (I_BUSY) state_d = CHK;
            CHK: begin
                if (!I_BUSY)        state_d = IDLE;
                else if (addrMatch) state_d = I_RW ? RD : WR_PTR;
                else                state_d = NACK;
            end
            WR_PTR: begin
                if (!I_BUSY)        state_d = IDLE;
                else if (I_DATA_VL) state_d = WR_DATA;
            end
            WR_DATA, RD, NACK: if (!I_BUSY) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Byte handling keys off the current state, so a final byte arriving with
    // I_BUSY already low is still written or counted before returning to IDLE.
    always_comb begin
        ptr_d     = ptr_q;
        wrEn      = 1'b0;
        wrStb_d   = 1'b0;
        wrIdx_d   = wrIdx_q;
        dataWr_d  = dataWr_q;
        ack_d     = (state_d == WR_PTR) || (state_d == WR_DATA) || (state_d == RD);
        appData_d = (I_APP_IDX == '0) ? ID_VAL : regs_q[I_APP_IDX];
        case (state_q)
            WR_PTR: begin
                if (I_DATA_VL) ptr_d = I_ADDR_REG[IDX_W-1:0];
            end
            WR_DATA: begin
                if (I_DATA_VL) begin
                    ptr_d = ptr_q + IDX_W'(1);
                    if (ptr_q != '0) begin
                        wrEn    = 1'b1;
                        wrStb_d = 1'b1;
                        wrIdx_d = ptr_q;
                    end
                end
            end
            RD: begin
                dataWr_d = (ptr_q == '0) ? ID_VAL : regs_q[ptr_q];
                if (I_DATA_VL) ptr_d = ptr_q + IDX_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            ptr_q     <= '0;
            ack_q     <= 1'b0;
            wrStb_q   <= 1'b0;
            wrIdx_q   <= '0;
            dataWr_q  <= '0;
            appData_q <= '0;
            for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
        end else begin
            ptr_q     <= ptr_d;
            ack_q     <= ack_d;
            wrStb_q   <= wrStb_d;
            wrIdx_q   <= wrIdx_d;
            dataWr_q  <= dataWr_d;
            appData_q <= appData_d;
            if (wrEn) regs_q[ptr_q] <= I_DATA_RD;
        end
    end

    assign O_ACK      = ack_q;
    assign O_WR_STB   = wrStb_q;
    assign O_WR_IDX   = wrIdx_q;
    assign O_DATA_WR  = dataWr_q;
    assign O_APP_DATA = appData_q;

endmodule

// File: tb/tb_slv_i2c_reg_bank.sv
// Scoreboard bench for slv_i2c_reg_bank: expected strobes and read bytes are
// queued as stimulus is driven and checked when the bank produces them.
module tb_slv_i2c_reg_bank;

    logic       CLK = 1'b0;
    logic       RST_n = 1'b1;
    logic       I_BUSY = 1'b0;
    logic [6:0] I_ADDR_SLV = '0;
    logic       I_RW = 1'b0;
    logic [7:0] I_ADDR_REG = '0;
    logic [7:0] I_DATA_RD = '0;
    logic       I_DATA_VL = 1'b0;
    logic [3:0] I_APP_IDX = '0;
    logic       O_ACK;
    logic [7:0] O_DATA_WR;
    logic       O_WR_STB;
    logic [3:0] O_WR_IDX;
    logic [7:0] O_APP_DATA;

    int testCount = 0;
    int failCount = 0;

    logic [7:0] mdlReg [16];
    logic [3:0] mdlPtr;
    int         wrQ[$];
    logic [7:0] rdQ[$];

    slv_i2c_reg_bank dut (
        .CLK(CLK), .RST_n(RST_n), .I_BUSY(I_BUSY), .I_ADDR_SLV(I_ADDR_SLV),
        .I_RW(I_RW), .I_ADDR_REG(I_ADDR_REG), .I_DATA_RD(I_DATA_RD),
        .I_DATA_VL(I_DATA_VL), .I_APP_IDX(I_APP_IDX), .O_ACK(O_ACK),
        .O_DATA_WR(O_DATA_WR), .O_WR_STB(O_WR_STB), .O_WR_IDX(O_WR_IDX),
        .O_APP_DATA(O_APP_DATA)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic busy, input logic [6:0] slv, input logic rw,
                                 input logic vl, input logic [7:0] addrReg, input logic [7:0] dataRd);
        I_BUSY     = busy;
        I_ADDR_SLV = slv;
        I_RW       = rw;
        I_DATA_VL  = vl;
        I_ADDR_REG = addrReg;
        I_DATA_RD  = dataRd;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [7:0] mdlRead(input logic [3:0] idx);
        return (idx == 4'd0) ? 8'hA5 : mdlReg[idx];
    endfunction

    // Each strobe seen must match the oldest queued write index.
    always @(negedge CLK) begin
        if (O_WR_STB === 1'b1) begin
            if (wrQ.size() == 0) checkOutput("unexpected_wr_stb", 1, 0);
            else checkOutput("wr_idx", {28'd0, O_WR_IDX}, wrQ.pop_front());
        end
    end

    task automatic writeTxn(input logic [6:0] slv, input logic [7:0] ptrByte, input int n,
                            input logic [7:0] b0, input logic [7:0] b1);
        logic       match;
        logic [7:0] bytes [2];
        match = (slv == 7'h2A);
        bytes[0] = b0;
        bytes[1] = b1;
        applyStimulus(1, slv, 0, 0, 8'h00, 8'h00);
        checkOutput("ack_in_chk", O_ACK, 0);
        applyStimulus(1, slv, 0, 0, 8'h00, 8'h00);
        checkOutput("ack_after_chk", O_ACK, match);
        applyStimulus(1, slv, 0, 1, ptrByte, 8'h00);
        if (match) mdlPtr = ptrByte[3:0];
        applyStimulus(1, slv, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < n; i++) begin
            if (match) begin
                if (mdlPtr != 4'd0) begin
                    mdlReg[mdlPtr] = bytes[i];
                    wrQ.push_back(int'(mdlPtr));
                end
                mdlPtr = mdlPtr + 4'd1;
            end
            applyStimulus(1, slv, 0, 1, 8'h00, bytes[i]);
            applyStimulus(1, slv, 0, 0, 8'h00, 8'h00);
            checkOutput("ack_hold_wr", O_ACK, match);
        end
        applyStimulus(0, slv, 0, 0, 8'h00, 8'h00);
        checkOutput("ack_stop_wr", O_ACK, 0);
        checkOutput("wr_stb_missing", wrQ.size(), 0);
    endtask

    task automatic readTxn(input int n);
        logic [3:0] p;
        for (int i = 0; i <= n; i++) begin
            p = mdlPtr + 4'(i);
            rdQ.push_back(mdlRead(p));
        end
        applyStimulus(1, 7'h2A, 1, 0, 8'h00, 8'h00);
        applyStimulus(1, 7'h2A, 1, 0, 8'h00, 8'h00);
        checkOutput("ack_rd", O_ACK, 1);
        applyStimulus(1, 7'h2A, 1, 0, 8'h00, 8'h00);
        checkOutput("rd_byte", O_DATA_WR, rdQ.pop_front());
        for (int i = 0; i < n; i++) begin
            applyStimulus(1, 7'h2A, 1, 1, 8'h00, 8'h00);
            mdlPtr = mdlPtr + 4'd1;
            applyStimulus(1, 7'h2A, 1, 0, 8'h00, 8'h00);
            checkOutput("rd_byte", O_DATA_WR, rdQ.pop_front());
        end
        applyStimulus(0, 7'h2A, 1, 0, 8'h00, 8'h00);
        checkOutput("ack_stop_rd", O_ACK, 0);
    endtask

    task automatic checkReg(input logic [3:0] idx);
        I_APP_IDX = idx;
        applyStimulus(0, 7'h00, 0, 0, 8'h00, 8'h00);
        checkOutput($sformatf("app_data[%0d]", idx), O_APP_DATA, mdlRead(idx));
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ack"}, O_ACK, 0);
        checkOutput({tag, "_wr_stb"}, O_WR_STB, 0);
        checkOutput({tag, "_wr_idx"}, O_WR_IDX, 0);
        checkOutput({tag, "_data_wr"}, O_DATA_WR, 0);
        checkOutput({tag, "_app_data"}, O_APP_DATA, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) mdlReg[i] = 8'h00;
        mdlPtr = 4'd0;
        #1 RST_n = 1'b0;
        #2 checkResetOutputs("por");
        @(posedge CLK);
        #1 RST_n = 1'b1;
        applyStimulus(0, 7'h00, 0, 0, 8'h00, 8'h00);

        // Matching write, then readback through the application port.
        writeTxn(7'h2A, 8'h03, 2, 8'h11, 8'h22);
        checkReg(4'd3);
        checkReg(4'd4);

        // Pointer-only write followed immediately by a read.
        writeTxn(7'h2A, 8'h03, 0, 8'h00, 8'h00);
        readTxn(2);

        // Foreign address must not move the pointer or touch registers.
        writeTxn(7'h10, 8'h04, 2, 8'h99, 8'h77);
        readTxn(0);
        checkReg(4'd4);

        // Wrap through read-only register 0.
        writeTxn(7'h2A, 8'h01, 1, 8'h3C, 8'h00);
        writeTxn(7'h2A, 8'h0F, 2, 8'hAA, 8'hBB);
        readTxn(1);
        checkReg(4'd15);
        checkReg(4'd0);
        writeTxn(7'h2A, 8'h00, 0, 8'h00, 8'h00);
        readTxn(0);

        // Upper pointer bits ignored.
        writeTxn(7'h2A, 8'hF2, 1, 8'h5C, 8'h00);
        readTxn(0);
        checkReg(4'd2);

        // Reset between data bytes, then a stray byte after release.
        applyStimulus(1, 7'h2A, 0, 0, 8'h00, 8'h00);
        applyStimulus(1, 7'h2A, 0, 0, 8'h00, 8'h00);
        applyStimulus(1, 7'h2A, 0, 1, 8'h06, 8'h00);
        mdlPtr = 4'd6;
        mdlReg[6] = 8'h66;
        wrQ.push_back(6);
        applyStimulus(1, 7'h2A, 0, 1, 8'h00, 8'h66);
        applyStimulus(1, 7'h2A, 0, 0, 8'h00, 8'h00);
        #2 RST_n = 1'b0;
        #1 checkResetOutputs("mid_rst");
        for (int i = 0; i < 16; i++) mdlReg[i] = 8'h00;
        mdlPtr = 4'd0;
        @(posedge CLK);
        #1 RST_n = 1'b1;
        applyStimulus(1, 7'h2A, 0, 1, 8'h00, 8'h77);
        applyStimulus(1, 7'h2A, 0, 0, 8'h00, 8'h00);
        applyStimulus(0, 7'h2A, 0, 0, 8'h00, 8'h00);
        checkOutput("ack_post_rst", O_ACK, 0);
        checkOutput("wr_stb_missing", wrQ.size(), 0);
        for (int i = 0; i < 16; i++) checkReg(4'(i));
        readTxn(0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
